// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM state
// encodings and the bubble constants that the flushed pipeline registers load.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2,
        HALT     = 2'd3
    } pipe_state_e;

    // addi x0, x0, 0 -- the canonical RISC-V NOP loaded into IF/ID on flush
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    // Destination register used by a bubble in ID/EX
    localparam logic [4:0]  RD_ZERO   = 5'd0;

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// MEM_WAIT watchdog: counts cycles spent waiting on data memory and flags
// expiry once MEM_TIMEOUT-1 has been reached. The counter parks at its last
// value until cleared, so expire stays stable while the FSM acts on it.
module pipe_ctrl_wdog #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = $clog2(MEM_TIMEOUT);
    localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] count;

    // Wait-cycle counter: cleared on entry to MEM_WAIT, advances while stalled
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expire) begin
            count <= count + W'(1);
        end
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 3-stage (IF/ID/EX) core. Drives the
// hold/flush controls of the PC, IF/ID and ID/EX registers to handle
// redirects, memory stalls, post-redirect fetch bubbles and halting.
// Optional macro PIPE_CTRL_PERF_EN adds saturating stall/flush counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 64
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic              halt_req,
    output logic              pc_hold,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_load_addr,
    output logic              if_id_hold,
    output logic              if_id_flush,
    output logic              id_ex_hold,
    output logic              id_ex_flush,
    output logic              mem_timeout,
    output logic              halted
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);
    // With no extra bubbles a redirect returns straight to RUN
    localparam pipe_state_e REDIRECT_STATE = (FLUSH_CYCLES == 0) ? RUN : FLUSH;

    pipe_state_e       state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              pend_vld, pend_vld_nxt;
    logic [ADDR_W-1:0] pend_addr, pend_addr_nxt;
    logic              wdog_clr, wdog_en, wdog_expire;
    logic              mem_stall;

    assign mem_stall = mem_req && !mem_ready;

    pipe_ctrl_wdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wdog (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clr     (wdog_clr),
        .en      (wdog_en),
        .expire  (wdog_expire)
    );

    // State register plus bubble counter and the redirect parked during a stall
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= RUN;
            cnt       <= '0;
            pend_vld  <= 1'b0;
            pend_addr <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pend_vld  <= pend_vld_nxt;
            pend_addr <= pend_addr_nxt;
        end
    end

    // Next-state logic; EX inputs are ignored outside RUN because EX is frozen or a bubble
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        pend_vld_nxt  = pend_vld;
        pend_addr_nxt = pend_addr;
        wdog_clr      = 1'b0;
        wdog_en       = 1'b0;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_nxt = MEM_WAIT;
                    wdog_clr  = 1'b1;
                    if (jump_en) begin
                        pend_vld_nxt  = 1'b1;
                        pend_addr_nxt = jump_addr;
                    end
                end else if (jump_en) begin
                    state_nxt = REDIRECT_STATE;
                    cnt_nxt   = FLUSH_INIT;
                end else if (halt_req) begin
                    state_nxt = HALT;
                end
            end
            MEM_WAIT: begin
                if (mem_ready || wdog_expire) begin
                    pend_vld_nxt  = 1'b0;
                    pend_addr_nxt = '0;
                    if (pend_vld) begin
                        state_nxt = REDIRECT_STATE;
                        cnt_nxt   = FLUSH_INIT;
                    end else begin
                        state_nxt = RUN;
                    end
                end else begin
                    wdog_en = 1'b1;
                end
            end
            FLUSH: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nxt = RUN;
                end
            end
            HALT: begin
                if (!halt_req) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Mealy control outputs; everything is forced low while reset is asserted
    always_comb begin
        pc_hold      = 1'b0;
        pc_load      = 1'b0;
        pc_load_addr = '0;
        if_id_hold   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_hold   = 1'b0;
        id_ex_flush  = 1'b0;
        mem_timeout  = 1'b0;
        halted       = 1'b0;
        if (!sys_rst) begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        pc_hold    = 1'b1;
                        if_id_hold = 1'b1;
                        id_ex_hold = 1'b1;
                    end else if (jump_en) begin
                        pc_load      = 1'b1;
                        pc_load_addr = jump_addr;
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready || wdog_expire) begin
                        mem_timeout = !mem_ready;
                        if (pend_vld) begin
                            pc_load      = 1'b1;
                            pc_load_addr = pend_addr;
                            if_id_flush  = 1'b1;
                            id_ex_flush  = 1'b1;
                        end
                    end else begin
                        pc_hold    = 1'b1;
                        if_id_hold = 1'b1;
                        id_ex_hold = 1'b1;
                    end
                end
                FLUSH: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                HALT: begin
                    halted      = 1'b1;
                    pc_hold     = 1'b1;
                    if_id_hold  = 1'b1;
                    id_ex_flush = 1'b1;
                end
                default: begin
                    pc_hold = 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Saturating performance counters for stall and flush cycles
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_hold && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (if_id_flush && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl. A stimulus process drives one cycle of
// inputs at a time and pushes the reference model's expected outputs into a
// scoreboard queue; a monitor on the falling edge pops and compares.
module tb_pipe_ctrl;

    localparam int ADDR_W       = 32;
    localparam int FLUSH_CYCLES = 1;
    localparam int MEM_TIMEOUT  = 4;

    typedef struct packed {
        logic              pc_hold;
        logic              pc_load;
        logic [ADDR_W-1:0] pc_load_addr;
        logic              if_id_hold;
        logic              if_id_flush;
        logic              id_ex_hold;
        logic              id_ex_flush;
        logic              mem_timeout;
        logic              halted;
    } ctrl_t;

    logic              sys_clk;
    logic              sys_rst;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic              mem_req;
    logic              mem_ready;
    logic              halt_req;
    logic              pc_hold;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_addr;
    logic              if_id_hold;
    logic              if_id_flush;
    logic              id_ex_hold;
    logic              id_ex_flush;
    logic              mem_timeout;
    logic              halted;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       flush_cnt;
`endif

    ctrl_t cur;
    assign cur = {pc_hold, pc_load, pc_load_addr, if_id_hold, if_id_flush,
                  id_ex_hold, id_ex_flush, mem_timeout, halted};

    pipe_ctrl #(
        .ADDR_W      (ADDR_W),
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .halt_req    (halt_req),
        .pc_hold     (pc_hold),
        .pc_load     (pc_load),
        .pc_load_addr(pc_load_addr),
        .if_id_hold  (if_id_hold),
        .if_id_flush (if_id_flush),
        .id_ex_hold  (id_ex_hold),
        .id_ex_flush (id_ex_flush),
        .mem_timeout (mem_timeout),
        .halted      (halted)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    ctrl_t exp_q[$];
    int    checks_total  = 0;
    int    checks_passed = 0;
    int    cycle_no      = 0;

    // Reference model: what the pipeline is doing, in plain terms
    bit              m_parked;
    bit              m_waiting;
    int              m_wait_age;
    bit              m_have_pend;
    logic [ADDR_W-1:0] m_pend;
    int              m_bubbles;

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    function automatic ctrl_t modelRedirect(input logic [ADDR_W-1:0] target);
        ctrl_t e;
        e              = '0;
        e.pc_load      = 1'b1;
        e.pc_load_addr = target;
        e.if_id_flush  = 1'b1;
        e.id_ex_flush  = 1'b1;
        m_bubbles      = FLUSH_CYCLES;
        return e;
    endfunction

    function automatic ctrl_t modelStep(input bit rst, input bit jump,
                                        input logic [ADDR_W-1:0] addr,
                                        input bit req, input bit rdy,
                                        input bit halt);
        ctrl_t e;
        e = '0;
        if (rst) begin
            m_parked    = 0;
            m_waiting   = 0;
            m_wait_age  = 0;
            m_have_pend = 0;
            m_pend      = '0;
            m_bubbles   = 0;
        end else if (m_parked) begin
            e.halted      = 1'b1;
            e.pc_hold     = 1'b1;
            e.if_id_hold  = 1'b1;
            e.id_ex_flush = 1'b1;
            if (!halt) m_parked = 0;
        end else if (m_bubbles > 0) begin
            e.if_id_flush = 1'b1;
            e.id_ex_flush = 1'b1;
            m_bubbles--;
        end else if (m_waiting) begin
            if (rdy || (m_wait_age == MEM_TIMEOUT - 1)) begin
                if (m_have_pend) e = modelRedirect(m_pend);
                e.mem_timeout = !rdy;
                m_waiting     = 0;
                m_have_pend   = 0;
            end else begin
                e.pc_hold    = 1'b1;
                e.if_id_hold = 1'b1;
                e.id_ex_hold = 1'b1;
                m_wait_age++;
            end
        end else if (req && !rdy) begin
            e.pc_hold    = 1'b1;
            e.if_id_hold = 1'b1;
            e.id_ex_hold = 1'b1;
            m_waiting    = 1;
            m_wait_age   = 0;
            if (jump) begin
                m_have_pend = 1;
                m_pend      = addr;
            end
        end else if (jump) begin
            e = modelRedirect(addr);
        end else if (halt) begin
            m_parked = 1;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input ctrl_t actual, input ctrl_t expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s (cycle %0d): got %h expected %h",
                     name, cycle_no, actual, expected);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and record the expectation
    task automatic applyStimulus(input bit rst, input bit jump,
                                 input logic [ADDR_W-1:0] addr,
                                 input bit req, input bit rdy, input bit halt);
        @(posedge sys_clk);
        #1;
        sys_rst   = rst;
        jump_en   = jump;
        jump_addr = addr;
        mem_req   = req;
        mem_ready = rdy;
        halt_req  = halt;
        cycle_no++;
        exp_q.push_back(modelStep(rst, jump, addr, req, rdy, halt));
    endtask

    // Monitor: compare the DUT against the oldest pending expectation
    always @(negedge sys_clk) begin
        if (exp_q.size() > 0) begin
            checkOutput("cycle outputs", cur, exp_q.pop_front());
        end
    end

    initial begin
        bit halt_lvl;
        sys_rst   = 1'b1;
        jump_en   = 1'b0;
        jump_addr = '0;
        mem_req   = 1'b0;
        mem_ready = 1'b0;
        halt_req  = 1'b0;
        void'(modelStep(1, 0, '0, 0, 0, 0));

        applyStimulus(1, 0, '0, 0, 0, 0);
        applyStimulus(1, 0, '0, 0, 0, 0);
        repeat (2) applyStimulus(0, 0, '0, 0, 0, 0);

        // Taken jump followed by one extra bubble
        applyStimulus(0, 1, 32'h100, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, '0, 0, 0, 0);

        // Memory stall released by ready after three wait cycles
        repeat (4) applyStimulus(0, 0, '0, 1, 0, 0);
        applyStimulus(0, 0, '0, 1, 1, 0);
        repeat (2) applyStimulus(0, 0, '0, 0, 0, 0);

        // Jump under a memory stall is parked and applied on ready
        repeat (3) applyStimulus(0, 1, 32'h200, 1, 0, 0);
        applyStimulus(0, 1, 32'h200, 1, 1, 0);
        repeat (3) applyStimulus(0, 0, '0, 0, 0, 0);

        // Ready never arrives: watchdog expiry
        repeat (6) applyStimulus(0, 0, '0, 1, 0, 0);
        repeat (2) applyStimulus(0, 0, '0, 0, 0, 0);

        // Watchdog expiry with a parked redirect
        repeat (5) applyStimulus(0, 1, 32'h240, 1, 0, 0);
        repeat (3) applyStimulus(0, 0, '0, 0, 0, 0);

        // Halt for five cycles
        repeat (5) applyStimulus(0, 0, '0, 0, 0, 1);
        repeat (3) applyStimulus(0, 0, '0, 0, 0, 0);

        // Reset in the middle of a stall with a parked redirect
        repeat (2) applyStimulus(0, 1, 32'h300, 1, 0, 0);
        applyStimulus(1, 1, 32'h300, 1, 0, 0);
        #1;
        checkOutput("async reset", cur, '0);
        applyStimulus(0, 0, '0, 1, 1, 0);
        repeat (2) applyStimulus(0, 0, '0, 0, 0, 0);

        // Randomised traffic
        halt_lvl = 0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 19) == 0) halt_lvl = !halt_lvl;
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 4) == 0,
                          $urandom,
                          $urandom_range(0, 2) == 0,
                          $urandom_range(0, 1) == 1,
                          halt_lvl);
        end
        applyStimulus(0, 0, '0, 0, 0, 0);

        // Let the monitor drain the scoreboard, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge sys_clk);
        #1;
        if (exp_q.size() > 0) begin
            checks_total++;
            $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
